// File: rtl/data_ram_hs_pkg.sv
// Shared types and constants for the handshaked byte-lane data memory.
// Defaults track the core's data bus width and data memory depth.
package data_ram_hs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int DATA_BUS_W        = 32;
    localparam int ADDR_BUS_W        = 32;
    localparam int DATA_MEM_NUM_LOG2 = 10;
    localparam int CNT_W             = 4;

    localparam logic WE_WRITE = 1'b1;
    localparam logic WE_READ  = 1'b0;

    // Number of byte-offset address bits for a word of data_w bits.
    function automatic int lane_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/data_ram_lane.sv
// One byte lane of the data memory: synchronous write port and a registered
// read whose output is forced to zero when the lane is not to be returned.
module data_ram_lane #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  rd_en,
    input  logic                  keep,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);

    logic [7:0] mem [0:(1 << DEPTH_LOG2)-1];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 8'h00;
        end else if (rd_en) begin
            rdata <= keep ? mem[addr] : 8'h00;
        end
    end

endmodule

// File: rtl/data_ram_hs.sv
// Byte-lane-enabled synchronous data memory with a single-outstanding
// request/response handshake, configurable wait states and range checking.
module data_ram_hs
    import data_ram_hs_pkg::*;
#(
    parameter int DATA_W      = DATA_BUS_W,
    parameter int ADDR_W      = ADDR_BUS_W,
    parameter int DEPTH_LOG2  = DATA_MEM_NUM_LOG2,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W/8-1:0] req_sel,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int LANES  = DATA_W / 8;
    localparam int LB     = lane_bits(DATA_W);
    localparam int IDX_HI = DEPTH_LOG2 + LB;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t                 state;
    state_t                 state_nxt;
    logic                   accept;
    logic                   load_rsp;
    logic                   we_q;
    logic                   err_q;
    logic [DEPTH_LOG2-1:0]  idx_q;
    logic [LANES-1:0]       sel_q;
    logic [CNT_W-1:0]       cnt;

    logic [DEPTH_LOG2-1:0]  req_idx;
    logic                   req_err;
    logic [DEPTH_LOG2-1:0]  cur_idx;
    logic                   cur_we;
    logic                   cur_err;
    logic [LANES-1:0]       cur_sel;
    logic [7:0]             lane_q [LANES];
    logic                   unused_addr_lsb;

    assign req_idx         = req_addr[IDX_HI-1:LB];
    assign req_err         = |req_addr[ADDR_W-1:IDX_HI];
    assign unused_addr_lsb = ^req_addr[LB-1:0];

    // With no wait states the response is loaded at the accepting edge, so the
    // read path must see the live request instead of the latched copy.
    always_comb begin
        cur_idx = idx_q;
        cur_we  = we_q;
        cur_err = err_q;
        cur_sel = sel_q;
        if (state == ST_IDLE) begin
            cur_idx = req_idx;
            cur_we  = req_we;
            cur_err = req_err;
            cur_sel = req_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        load_rsp  = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_nxt = ST_WAIT;
                    end else begin
                        state_nxt = ST_RESP;
                        load_rsp  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ST_RESP;
                    load_rsp  = 1'b1;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q  <= WE_READ;
            err_q <= 1'b0;
            idx_q <= '0;
            sel_q <= '0;
        end else if (accept) begin
            we_q  <= req_we;
            err_q <= req_err;
            idx_q <= req_idx;
            sel_q <= req_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_LOAD;
        end else if (state == ST_WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err <= 1'b0;
        end else if (load_rsp) begin
            rsp_err <= cur_err;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        data_ram_lane #(
            .DEPTH_LOG2 (DEPTH_LOG2)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .we    (accept && req_we == WE_WRITE && !req_err && req_sel[i]),
            .rd_en (load_rsp),
            .keep  (cur_sel[i] && cur_we == WE_READ && !cur_err),
            .addr  (cur_idx),
            .wdata (req_wdata[8*i +: 8]),
            .rdata (lane_q[i])
        );
    end

    always_comb begin
        rsp_rdata = '0;
        for (int i = 0; i < LANES; i++) begin
            rsp_rdata[8*i +: 8] = lane_q[i];
        end
    end

endmodule

// File: tb/tb_data_ram_hs.sv
// Bench for data_ram_hs: one instance with no wait states, one with three.
module tb_data_ram_hs;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [3:0]  req_sel   [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int checks   = 0;
    int failures = 0;

    logic [7:0] mdl [2][1024][4];

    always #5 clk = ~clk;

    data_ram_hs #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_sel(req_sel[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_ram_hs #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_sel(req_sel[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] exp_r;
        logic        exp_e;
    } vec_t;

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: memory is a plain byte array; anything at or above 4 KiB is an error.
    task automatic model_txn(input int d, input logic we, input logic [31:0] addr,
                             input logic [3:0] sel, input logic [31:0] wdata,
                             output logic [31:0] exp_r, output logic exp_e);
        int idx;
        idx   = int'((addr / 4) % 1024);
        exp_e = (addr >= 32'h1000);
        exp_r = 32'h0;
        if (!exp_e) begin
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) begin
                    if (we) mdl[d][idx][i] = 8'((wdata >> (8 * i)) & 32'hFF);
                    else    exp_r = exp_r | (32'(mdl[d][idx][i]) << (8 * i));
                end
            end
        end
    endtask

    task automatic drive_req(input int d, input logic we, input logic [31:0] addr,
                             input logic [3:0] sel, input logic [31:0] wdata);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_sel[d]   = sel;
        req_wdata[d] = wdata;
    endtask

    task automatic do_txn(input int d, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wdata, input int hold,
                          output logic [31:0] r, output logic e,
                          output logic [31:0] mr, output logic me);
        int w;
        w = wait_of(d);
        @(negedge clk);
        chk("idle_ready", 32'(req_ready[d]), 32'd1);
        drive_req(d, we, addr, sel, wdata);
        @(posedge clk);
        model_txn(d, we, addr, sel, wdata, mr, me);
        #1 req_valid[d] = 1'b0;
        for (int n = 1; n <= w + 1; n++) begin
            @(negedge clk);
            chk("latency_valid", 32'(rsp_valid[d]), 32'(n == w + 1));
            chk("busy_ready", 32'(req_ready[d]), 32'd0);
        end
        r = rsp_rdata[d];
        e = rsp_err[d];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
            chk("hold_rdata", rsp_rdata[d], r);
            chk("hold_err", 32'(rsp_err[d]), 32'(e));
            chk("hold_ready", 32'(req_ready[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[d] = 1'b0;
        @(negedge clk);
        chk("post_valid", 32'(rsp_valid[d]), 32'd0);
        chk("post_ready", 32'(req_ready[d]), 32'd1);
    endtask

    vec_t tbl [14];

    initial begin
        logic [31:0] r, mr, a;
        logic        e, me, we;
        int          spur;

        tbl[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h0000_0010, 4'h1, 32'h000000AA, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 32'h0000_0010, 4'h3, 32'h0,        32'h0000BEAA, 1'b0};
        tbl[4]  = '{1'b0, 32'h0000_0010, 4'hC, 32'h0,        32'hDEAD0000, 1'b0};
        tbl[5]  = '{1'b1, 32'h0000_0000, 4'hF, 32'h12345678, 32'h0,        1'b0};
        tbl[6]  = '{1'b1, 32'h0000_1000, 4'hF, 32'hFFFFFFFF, 32'h0,        1'b1};
        tbl[7]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,        32'h12345678, 1'b0};
        tbl[8]  = '{1'b0, 32'h0000_1000, 4'hF, 32'h0,        32'h0,        1'b1};
        tbl[9]  = '{1'b1, 32'h0000_0010, 4'h0, 32'h11111111, 32'h0,        1'b0};
        tbl[10] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,        32'hDEADBEAA, 1'b0};
        tbl[11] = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,        32'h0,        1'b0};
        tbl[12] = '{1'b0, 32'h0000_0013, 4'hF, 32'h0,        32'hDEADBEAA, 1'b0};
        tbl[13] = '{1'b0, 32'h8000_0010, 4'hF, 32'h0,        32'h0,        1'b1};

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_sel[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(req_ready[d]), 32'd1);
            chk("rst_valid", 32'(rsp_valid[d]), 32'd0);
            chk("rst_rdata", rsp_rdata[d], 32'h0);
            chk("rst_err", 32'(rsp_err[d]), 32'd0);
        end

        // Directed vectors with hand-derived expectations (no wait states).
        for (int i = 0; i < 14; i++) begin
            do_txn(0, tbl[i].we, tbl[i].addr, tbl[i].sel, tbl[i].wdata, 0, r, e, mr, me);
            chk($sformatf("tbl%0d_rdata", i), r, tbl[i].exp_r);
            chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].exp_e));
        end

        // Random traffic on a small initialised window plus out-of-range hits.
        for (int i = 0; i < 16; i++) begin
            do_txn(0, 1'b1, 32'(i * 4), 4'hF, $urandom, 0, r, e, mr, me);
        end
        for (int i = 0; i < 200; i++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0)
                a = (32'h1 << $urandom_range(12, 31)) | ($urandom & 32'h3F);
            else
                a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            do_txn(0, we, a, 4'($urandom_range(0, 15)), $urandom,
                   int'($urandom_range(0, 2)), r, e, mr, me);
            chk("rnd_rdata", r, mr);
            chk("rnd_err", 32'(e), 32'(me));
        end

        // Three wait states with the consumer stalling for two cycles.
        do_txn(1, 1'b1, 32'h40, 4'hF, 32'hCAFEF00D, 0, r, e, mr, me);
        do_txn(1, 1'b0, 32'h40, 4'hF, 32'h0, 2, r, e, mr, me);
        chk("w3_rdata", r, 32'hCAFEF00D);
        chk("w3_err", 32'(e), 32'd0);

        // Reset while a read waits: no response may appear afterwards.
        @(negedge clk);
        drive_req(1, 1'b0, 32'h40, 4'hF, 32'h0);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        chk("wait_ready", 32'(req_ready[1]), 32'd0);
        #1 rst[1] = 1'b1;
        #1;
        chk("async_ready", 32'(req_ready[1]), 32'd1);
        chk("async_valid", 32'(rsp_valid[1]), 32'd0);
        @(negedge clk);
        rst[1] = 1'b0;
        spur = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid[1]) spur++;
        end
        chk("no_spurious_rsp", 32'(spur), 32'd0);

        // Reset while a response is held clears it at once.
        @(negedge clk);
        drive_req(1, 1'b0, 32'h40, 4'hF, 32'h0);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        repeat (5) @(negedge clk);
        chk("held_valid", 32'(rsp_valid[1]), 32'd1);
        chk("held_rdata", rsp_rdata[1], 32'hCAFEF00D);
        #1 rst[1] = 1'b1;
        #1;
        chk("rst_resp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("rst_resp_rdata", rsp_rdata[1], 32'h0);
        @(negedge clk);
        rst[1] = 1'b0;

        // A write accepted before a reset stays committed.
        @(negedge clk);
        drive_req(1, 1'b1, 32'h44, 4'hF, 32'hDEADC0DE);
        @(posedge clk);
        model_txn(1, 1'b1, 32'h44, 4'hF, 32'hDEADC0DE, mr, me);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        #1 rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        do_txn(1, 1'b0, 32'h44, 4'hF, 32'h0, 0, r, e, mr, me);
        chk("write_survives_rst", r, 32'hDEADC0DE);

        // Back-to-back: request held valid with four queued, consumer always ready.
        begin
            vec_t        q [4];
            logic [32:0] expq [$];
            int          acc [$];
            int          cyc, ri, nrsp;
            logic        got_acc;
            logic [32:0] ex;
            q[0] = '{1'b1, 32'h48, 4'hF, 32'h0BADF00D, 32'h0, 1'b0};
            q[1] = '{1'b0, 32'h48, 4'h6, 32'h0,        32'h0, 1'b0};
            q[2] = '{1'b0, 32'h40, 4'hF, 32'h0,        32'h0, 1'b0};
            q[3] = '{1'b0, 32'h44, 4'h9, 32'h0,        32'h0, 1'b0};
            cyc = 0; ri = 0; nrsp = 0;
            rsp_ready[1] = 1'b1;
            @(negedge clk);
            drive_req(1, q[0].we, q[0].addr, q[0].sel, q[0].wdata);
            for (int k = 0; k < 80 && nrsp < 4; k++) begin
                got_acc = req_valid[1] && req_ready[1];
                if (rsp_valid[1]) begin
                    if (expq.size() == 0) begin
                        chk("b2b_unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        ex = expq.pop_front();
                        chk("b2b_rdata", rsp_rdata[1], ex[31:0]);
                        chk("b2b_err", 32'(rsp_err[1]), 32'(ex[32]));
                    end
                    nrsp++;
                end
                @(posedge clk);
                if (got_acc) begin
                    model_txn(1, q[ri].we, q[ri].addr, q[ri].sel, q[ri].wdata, mr, me);
                    expq.push_back({me, mr});
                    acc.push_back(cyc);
                    ri++;
                end
                #1;
                if (ri < 4) drive_req(1, q[ri].we, q[ri].addr, q[ri].sel, q[ri].wdata);
                else        req_valid[1] = 1'b0;
                @(negedge clk);
                cyc++;
            end
            rsp_ready[1] = 1'b0;
            chk("b2b_accepts", 32'(acc.size()), 32'd4);
            chk("b2b_responses", 32'(nrsp), 32'd4);
            for (int i = 1; i < acc.size(); i++) begin
                chk("b2b_interval", 32'(acc[i] - acc[i-1]), 32'd5);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_ram_hs.md
Name: data_ram_hs

Overview:
- Parametrised, byte-lane-enabled synchronous data memory for the MEM stage, replacing the combinational-read data RAM.
- Single-outstanding request/response handshake with a configurable wait-state count, so the pipeline can be tested against slower memory.
- Detects out-of-range addresses and returns an error flag instead of aliasing.
- Unselected byte lanes are returned as zero, so the load-extension logic sees clean data.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8; lanes = DATA_W/8.
- ADDR_W, 32, byte-address width.
- DEPTH_LOG2, 10, log2 of the number of words (default 1024 words).
- WAIT_CYCLES, 0, extra cycles between request acceptance and response (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address; bits [LB-1:0] are ignored (word-aligned), where LB = log2(DATA_W/8).
- req_sel  in  DATA_W/8  byte-lane enables; lane i = bits [8i+7:8i].
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  read data, unselected lanes zero; zero for writes.
- rsp_err  out  1  address out of range.

Behaviour:
- Storage: one byte array per lane, 2^DEPTH_LOG2 entries each; word index = req_addr[DEPTH_LOG2+LB-1:LB].
- Range check: err = |req_addr[ADDR_W-1:DEPTH_LOG2+LB].
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch we, index, sel and err.
  - Write with !err: commit the selected lanes at this same edge.
  - Go to WAIT if WAIT_CYCLES > 0, else to RESP.
- WAIT:
  - req_ready = 0.
  - A down-counter is loaded with WAIT_CYCLES-1 on acceptance.
  - When the count reaches 0, go to RESP.
- Entering RESP:
  - rsp_rdata is registered from the array for reads without err, with selected lanes kept and others zeroed.
  - Otherwise rsp_rdata = 0.
  - rsp_err = latched err.
- RESP:
  - rsp_valid = 1 and req_ready = 0.
  - rsp_rdata and rsp_err stay stable until rsp_valid && rsp_ready.
  - On that handshake, go to IDLE.
  - rsp_valid drops next cycle; no back-to-back acceptance in the same cycle.
- Latency: an accept at edge T gives rsp_valid high from T+1+WAIT_CYCLES.
  - Throughput is at best one request per 2+WAIT_CYCLES cycles.
- Read-after-write: a read accepted after a write's response returns the new data.
  - Writes commit at acceptance, so there is no hazard window.
- Out-of-range write: array untouched; response has rsp_err = 1 and rdata = 0.
- req_sel = 0:
  - Write: no change, normal ack.
  - Read: rdata = 0, err as computed.
- Reset (asynchronous, any state):
  - FSM to IDLE; rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, counter = 0.
  - req_ready = 1 after reset deasserts.
  - Array contents are NOT reset.
  - An in-flight read response is discarded; an in-flight write already committed stays committed.
- Inputs other than req_valid are don't-care when req_valid = 0 or the FSM is not in IDLE.

Decomposition:
- Shared package/defines:
  - FSM state encoding (IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2).
  - Default width/depth constants, aligned with the existing DataBus / DataMemNum defines.
  - Write/read enable constants.
- One natural sub-module, data_ram_lane: a single byte-wide array with its write enable and registered read, instantiated DATA_W/8 times in a generate loop.
- The FSM, counter and range check stay in the top module.

Test Plan:
- Write 0xDEADBEEF to addr 0x10 with sel 4'b1111, then read addr 0x10 with sel 4'b1111 (WAIT_CYCLES=0) -> rsp_valid 1 cycle after each accept; read returns 0xDEADBEEF, rsp_err = 0.
- Byte writes: from the previous state, write 0x000000AA at 0x10 with sel 4'b0001, then read with sel 4'b0011 -> 0x0000BEAA; read with sel 4'b1100 -> 0xDEAD0000.
- Out of range: write to 0x1000 (DEPTH_LOG2=10) -> rsp_err = 1; a following read of 0x0000 is unchanged from its prior value; a read of 0x1000 gives rsp_err = 1, rdata = 0.
- WAIT_CYCLES=3 with rsp_ready held low for 2 extra cycles:
  - rsp_valid asserts at T+4;
  - rdata stays stable while held;
  - req_ready stays 0 until the cycle after the handshake.
- Reset in WAIT:
  - assert rst mid-read -> rsp_valid and req_ready drop/rise immediately (async), with no later spurious response;
  - a write accepted before the reset is still readable after it.
- Back-to-back: req_valid held high with 4 queued requests -> exactly one accept per 2+WAIT_CYCLES cycles, with responses in order.
